// File: rtl/moore_seq_gen_if.sv
// moore_seq_gen_if -- control and status bundle for moore_seq_gen.
//
// Parameters:
//   NUM_STATES : number of sequence states (2..16)
//   OUT_W      : width of the per-state output word (1..16)
//
// Signals (direction as seen by the generator, i.e. the slave modport):
//   en          in   advance the sequence by one step
//   mode        in   0 free-run, 1 one-shot, 2 ping-pong, 3 same as 0
//   dir         in   0 up, 1 down (modes 0/1)
//   load        in   force the state to load_state
//   load_state  in   target state for load
//   wr_en       in   output-table write strobe
//   wr_addr     in   output-table write address
//   wr_data     in   output-table write data
//   state_out   out  current state index
//   out         out  output word of the current state
//   wrap        out  one-cycle pulse on a sequence boundary
//   done        out  one-shot terminal state reached
interface moore_seq_gen_if #(
  parameter int NUM_STATES = 4,
  parameter int OUT_W      = 1
);
  localparam int STATE_W = $clog2(NUM_STATES);

  logic               en;
  logic [1:0]         mode;
  logic               dir;
  logic               load;
  logic [STATE_W-1:0] load_state;
  logic               wr_en;
  logic [STATE_W-1:0] wr_addr;
  logic [OUT_W-1:0]   wr_data;
  logic [STATE_W-1:0] state_out;
  logic [OUT_W-1:0]   out;
  logic               wrap;
  logic               done;

  modport master (
    output en, mode, dir, load, load_state, wr_en, wr_addr, wr_data,
    input  state_out, out, wrap, done
  );

  modport slave (
    input  en, mode, dir, load, load_state, wr_en, wr_addr, wr_data,
    output state_out, out, wrap, done
  );
endinterface

// File: rtl/moore_seq_gen.sv
// moore_seq_gen -- programmable Moore sequence generator.
//
// Steps through NUM_STATES states in free-run, one-shot or ping-pong order
// and presents a per-state output word from a small lookup table. All
// outputs are registered; out always equals table[state_out].
//
// Build option: define MOORE_SEQ_TABLE_WR_EN to make the output table
// writable through wr_en/wr_addr/wr_data. Without it the table is the
// constant pattern entry[i] = i (truncated/zero-extended to OUT_W) and the
// write port is ignored.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : moore_seq_gen_if.slave (controls, table write port, status)
module moore_seq_gen #(
  parameter int NUM_STATES = 4,
  parameter int OUT_W      = 1
) (
  input  logic           clk,
  input  logic           rst,
  moore_seq_gen_if.slave bus
);
  localparam int STATE_W = $clog2(NUM_STATES);
  localparam logic [STATE_W-1:0] ZERO_S = STATE_W'(32'd0);
  localparam logic [STATE_W-1:0] ONE_S  = STATE_W'(32'd1);
  localparam logic [STATE_W-1:0] LAST_S = STATE_W'(NUM_STATES - 1);

  // Reset-time table contents: entry i holds i truncated/zero-extended.
  function automatic logic [OUT_W-1:0] init_entry(input logic [STATE_W-1:0] idx);
    return OUT_W'(idx);
  endfunction

  // True when an index addresses a real state (matters for non-power-of-two).
  function automatic logic state_valid(input logic [STATE_W-1:0] idx);
    return (32'(idx) < 32'(NUM_STATES));
  endfunction

  logic [STATE_W-1:0] state_r;
  logic [OUT_W-1:0]   out_r;
  logic               wrap_r;
  logic               done_r;
  logic               pp_down_r;

  logic [STATE_W-1:0] cur_s;
  logic [STATE_W-1:0] state_n_s;
  logic [STATE_W-1:0] term_s;
  logic               wrap_n_s;
  logic               done_n_s;
  logic               done_d_s;
  logic               pp_down_n_s;
  logic               down_s;
  logic [OUT_W-1:0]   tbl_s;
  logic               wr_ok_s;

  assign wr_ok_s = bus.wr_en & state_valid(bus.wr_addr);

  // Next-state, boundary pulse, one-shot flag and ping-pong direction.
  always_comb begin
    // Any out-of-range value is treated as state 0 so the sequence recovers.
    if (state_valid(state_r)) begin
      cur_s = state_r;
    end else begin
      cur_s = ZERO_S;
    end
    state_n_s   = cur_s;
    wrap_n_s    = 1'b0;
    done_n_s    = done_r;
    pp_down_n_s = pp_down_r;
    down_s      = pp_down_r;
    term_s      = bus.dir ? ZERO_S : LAST_S;

    if (bus.load) begin
      if (state_valid(bus.load_state)) begin
        state_n_s = bus.load_state;
      end else begin
        state_n_s = ZERO_S;
      end
      done_n_s    = 1'b0;
      pp_down_n_s = 1'b0;
    end else if (bus.en) begin
      case (bus.mode)
        2'd1: begin
          if (done_r) begin
            // Terminal reached: further steps are ignored until load/mode change.
            state_n_s = cur_s;
          end else if (cur_s == term_s) begin
            // Started at the terminal: flag it without moving.
            done_n_s = 1'b1;
            wrap_n_s = 1'b1;
          end else begin
            state_n_s = bus.dir ? (cur_s - ONE_S) : (cur_s + ONE_S);
            if (state_n_s == term_s) begin
              done_n_s = 1'b1;
              wrap_n_s = 1'b1;
            end else begin
              done_n_s = 1'b0;
            end
          end
        end
        2'd2: begin
          // Turn around at the ends so no end state is repeated, even after a load.
          if (cur_s == LAST_S) begin
            down_s = 1'b1;
          end else if (cur_s == ZERO_S) begin
            down_s = 1'b0;
          end else begin
            down_s = pp_down_r;
          end
          state_n_s = down_s ? (cur_s - ONE_S) : (cur_s + ONE_S);
          wrap_n_s  = (state_n_s == LAST_S) || (state_n_s == ZERO_S);
          if (state_n_s == LAST_S) begin
            pp_down_n_s = 1'b1;
          end else if (state_n_s == ZERO_S) begin
            pp_down_n_s = 1'b0;
          end else begin
            pp_down_n_s = down_s;
          end
        end
        default: begin
          // Modes 0 and 3: modulo counter in the requested direction.
          if (bus.dir) begin
            state_n_s = (cur_s == ZERO_S) ? LAST_S : (cur_s - ONE_S);
            wrap_n_s  = (cur_s == ZERO_S);
          end else begin
            state_n_s = (cur_s == LAST_S) ? ZERO_S : (cur_s + ONE_S);
            wrap_n_s  = (cur_s == LAST_S);
          end
        end
      endcase
    end else begin
      state_n_s = cur_s;
    end
  end

  // done only survives while the one-shot mode stays selected.
  assign done_d_s = done_n_s & (bus.mode == 2'd1);

`ifdef MOORE_SEQ_TABLE_WR_EN
  logic [OUT_W-1:0] table_r [NUM_STATES];

  // Writable output table, restored to its default pattern on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        table_r[i] <= init_entry(STATE_W'(i));
      end
    end else if (wr_ok_s) begin
      table_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Table read for the next state; a same-edge write to that entry wins.
  always_comb begin
    if (wr_ok_s && (bus.wr_addr == state_n_s)) begin
      tbl_s = bus.wr_data;
    end else begin
      tbl_s = table_r[state_n_s];
    end
  end
`else
  logic unused_wr_s;

  assign unused_wr_s = ^{wr_ok_s, bus.wr_addr, bus.wr_data};

  // Fixed output table.
  always_comb begin
    tbl_s = init_entry(state_n_s);
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ZERO_S;
      out_r     <= init_entry(ZERO_S);
      wrap_r    <= 1'b0;
      done_r    <= 1'b0;
      pp_down_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      out_r     <= tbl_s;
      wrap_r    <= wrap_n_s;
      done_r    <= done_d_s;
      pp_down_r <= pp_down_n_s;
    end
  end

  assign bus.state_out = state_r;
  assign bus.out       = out_r;
  assign bus.wrap      = wrap_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_moore_seq_gen.sv
// tb_moore_seq_gen -- self-checking bench for moore_seq_gen.
// Two instances: u4 (NUM_STATES=4, OUT_W=1) and u5 (NUM_STATES=5, OUT_W=8).
// A table of stimulus/expected records is applied one per clock; expected
// records go into a queue when driven and are compared after the edge.
module tb_moore_seq_gen;
  typedef struct packed {
    logic       sel;    // 0 = u4, 1 = u5
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic       load;
    logic [3:0] ld;
    logic       wr;
    logic [3:0] wa;
    logic [7:0] wd;
    logic [3:0] e_state;
    logic [7:0] e_out;
    logic       e_wrap;
    logic       e_done;
  } vec_t;

`ifdef MOORE_SEQ_TABLE_WR_EN
  localparam logic [7:0] W_A5 = 8'hA5;
  localparam logic [7:0] W_3C = 8'h3C;
  localparam logic [7:0] W_77 = 8'h77;
`else
  localparam logic [7:0] W_A5 = 8'h02;
  localparam logic [7:0] W_3C = 8'h02;
  localparam logic [7:0] W_77 = 8'h04;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  vec_t vecs[$];
  vec_t exp_q[$];

  moore_seq_gen_if #(.NUM_STATES(4), .OUT_W(1)) i4 ();
  moore_seq_gen_if #(.NUM_STATES(5), .OUT_W(8)) i5 ();

  moore_seq_gen #(.NUM_STATES(4), .OUT_W(1)) u4 (.clk(clk), .rst(rst), .bus(i4));
  moore_seq_gen #(.NUM_STATES(5), .OUT_W(8)) u5 (.clk(clk), .rst(rst), .bus(i5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic sel, input logic en, input logic [1:0] mode,
                              input logic dir, input logic load, input logic [3:0] ld,
                              input logic wr, input logic [3:0] wa, input logic [7:0] wd,
                              input logic [3:0] es, input logic [7:0] eo,
                              input logic ew, input logic ed);
    vec_t v;
    v.sel = sel; v.en = en; v.mode = mode; v.dir = dir; v.load = load; v.ld = ld;
    v.wr = wr; v.wa = wa; v.wd = wd;
    v.e_state = es; v.e_out = eo; v.e_wrap = ew; v.e_done = ed;
    return v;
  endfunction

  // Shorthand for a vector without table writes.
  function automatic vec_t mv(input logic sel, input logic en, input logic [1:0] mode,
                              input logic dir, input logic load, input logic [3:0] ld,
                              input logic [3:0] es, input logic [7:0] eo,
                              input logic ew, input logic ed);
    return mk(sel, en, mode, dir, load, ld, 1'b0, 4'd0, 8'd0, es, eo, ew, ed);
  endfunction

  task automatic drive(input vec_t v);
    if (v.sel == 1'b0) begin
      i4.en = v.en; i4.mode = v.mode; i4.dir = v.dir; i4.load = v.load;
      i4.load_state = v.ld[1:0]; i4.wr_en = v.wr; i4.wr_addr = v.wa[1:0];
      i4.wr_data = v.wd[0];
      i5.en = 1'b0; i5.load = 1'b0; i5.wr_en = 1'b0;
    end else begin
      i5.en = v.en; i5.mode = v.mode; i5.dir = v.dir; i5.load = v.load;
      i5.load_state = v.ld[2:0]; i5.wr_en = v.wr; i5.wr_addr = v.wa[2:0];
      i5.wr_data = v.wd;
      i4.en = 1'b0; i4.load = 1'b0; i4.wr_en = 1'b0;
    end
  endtask

  task automatic check(input string name, input vec_t e);
    logic [3:0] as;
    logic [7:0] ao;
    logic       aw;
    logic       ad;
    if (e.sel == 1'b0) begin
      as = {2'b00, i4.state_out}; ao = {7'd0, i4.out}; aw = i4.wrap; ad = i4.done;
    end else begin
      as = {1'b0, i5.state_out}; ao = i5.out; aw = i5.wrap; ad = i5.done;
    end
    n_checks++;
    if (as === e.e_state && ao === e.e_out && aw === e.e_wrap && ad === e.e_done) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got state=%0d out=%h wrap=%b done=%b, expected state=%0d out=%h wrap=%b done=%b",
               name, as, ao, aw, ad, e.e_state, e.e_out, e.e_wrap, e.e_done);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("vec%0d", idx), e);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    i4.en = 1'b0; i4.mode = 2'd0; i4.dir = 1'b0; i4.load = 1'b0; i4.load_state = 2'd0;
    i4.wr_en = 1'b0; i4.wr_addr = 2'd0; i4.wr_data = 1'b0;
    i5.en = 1'b0; i5.mode = 2'd0; i5.dir = 1'b0; i5.load = 1'b0; i5.load_state = 3'd0;
    i5.wr_en = 1'b0; i5.wr_addr = 3'd0; i5.wr_data = 8'd0;

    // u4: free-run up (8 steps), hold, down, mode 3
    vecs.push_back(mv(0,1,0,0,0,0, 1,1,0,0)); vecs.push_back(mv(0,1,0,0,0,0, 2,0,0,0));
    vecs.push_back(mv(0,1,0,0,0,0, 3,1,0,0)); vecs.push_back(mv(0,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mv(0,1,0,0,0,0, 1,1,0,0)); vecs.push_back(mv(0,1,0,0,0,0, 2,0,0,0));
    vecs.push_back(mv(0,1,0,0,0,0, 3,1,0,0)); vecs.push_back(mv(0,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mv(0,0,0,0,0,0, 0,0,0,0));
    vecs.push_back(mv(0,1,0,1,0,0, 3,1,1,0)); vecs.push_back(mv(0,1,0,1,0,0, 2,0,0,0));
    vecs.push_back(mv(0,1,3,0,0,0, 3,1,0,0)); vecs.push_back(mv(0,1,3,0,0,0, 0,0,1,0));
    // u4: ping-pong from 0
    vecs.push_back(mv(0,0,2,0,1,0, 0,0,0,0));
    vecs.push_back(mv(0,1,2,0,0,0, 1,1,0,0)); vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0));
    vecs.push_back(mv(0,1,2,0,0,0, 3,1,1,0)); vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0));
    vecs.push_back(mv(0,1,2,0,0,0, 1,1,0,0)); vecs.push_back(mv(0,1,2,0,0,0, 0,0,1,0));
    vecs.push_back(mv(0,1,2,0,0,0, 1,1,0,0)); vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0));
    // u4: load beats en, one-shot up, done held, mode change clears, start at terminal
    vecs.push_back(mv(0,1,0,0,1,2, 2,0,0,0));
    vecs.push_back(mv(0,1,1,0,0,0, 3,1,1,1)); vecs.push_back(mv(0,1,1,0,0,0, 3,1,0,1));
    vecs.push_back(mv(0,0,1,0,0,0, 3,1,0,1)); vecs.push_back(mv(0,1,1,1,0,0, 3,1,0,1));
    vecs.push_back(mv(0,0,0,0,0,0, 3,1,0,0)); vecs.push_back(mv(0,1,1,0,0,0, 3,1,1,1));
    vecs.push_back(mv(0,1,1,0,1,1, 1,1,0,0));
    // u4: ping-pong after load, including load to the top end
    vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0)); vecs.push_back(mv(0,1,2,0,0,0, 3,1,1,0));
    vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0));
    vecs.push_back(mv(0,0,2,0,1,3, 3,1,0,0)); vecs.push_back(mv(0,1,2,0,0,0, 2,0,0,0));
    // u5: one-shot down from 3
    vecs.push_back(mv(1,0,1,1,1,3, 3,3,0,0));
    vecs.push_back(mv(1,1,1,1,0,0, 2,2,0,0)); vecs.push_back(mv(1,1,1,1,0,0, 1,1,0,0));
    vecs.push_back(mv(1,1,1,1,0,0, 0,0,1,1)); vecs.push_back(mv(1,1,1,1,0,0, 0,0,0,1));
    vecs.push_back(mv(1,0,1,1,0,0, 0,0,0,1));
    vecs.push_back(mv(1,0,1,1,1,2, 2,2,0,0)); vecs.push_back(mv(1,1,1,1,0,0, 1,1,0,0));
    // u5: out-of-range load, free-run wrap at 5 states
    vecs.push_back(mv(1,1,0,0,1,7, 0,0,0,0));
    vecs.push_back(mv(1,1,0,0,0,0, 1,1,0,0)); vecs.push_back(mv(1,1,0,0,0,0, 2,2,0,0));
    vecs.push_back(mv(1,1,0,0,0,0, 3,3,0,0)); vecs.push_back(mv(1,1,0,0,0,0, 4,4,0,0));
    vecs.push_back(mv(1,1,0,0,0,0, 0,0,1,0)); vecs.push_back(mv(1,1,0,1,0,0, 4,4,1,0));
    // u5: ping-pong with 5 states
    vecs.push_back(mv(1,0,2,0,1,0, 0,0,0,0));
    vecs.push_back(mv(1,1,2,0,0,0, 1,1,0,0)); vecs.push_back(mv(1,1,2,0,0,0, 2,2,0,0));
    vecs.push_back(mv(1,1,2,0,0,0, 3,3,0,0)); vecs.push_back(mv(1,1,2,0,0,0, 4,4,1,0));
    vecs.push_back(mv(1,1,2,0,0,0, 3,3,0,0)); vecs.push_back(mv(1,1,2,0,0,0, 2,2,0,0));
    vecs.push_back(mv(1,1,2,0,0,0, 1,1,0,0)); vecs.push_back(mv(1,1,2,0,0,0, 0,0,1,0));
    vecs.push_back(mv(1,1,2,0,0,0, 1,1,0,0));
    // u5: table writes (bypass on entry, out-of-range address, held-state write)
    vecs.push_back(mv(1,0,0,0,1,1, 1,1,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 1,2,8'hA5, 2,W_A5,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,6,8'hFF, 2,W_A5,0,0));
    vecs.push_back(mv(1,1,0,0,0,0, 3,3,0,0));
    vecs.push_back(mv(1,0,0,0,1,2, 2,W_A5,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,2,8'h3C, 2,W_3C,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 1,4,8'h77, 2,W_3C,0,0));
    vecs.push_back(mv(1,1,0,0,0,0, 3,3,0,0)); vecs.push_back(mv(1,1,0,0,0,0, 4,W_77,0,0));
    // u4: reach one-shot terminal (state 3, done=1) before the reset test
    vecs.push_back(mv(0,0,1,0,1,2, 2,0,0,0)); vecs.push_back(mv(0,1,1,0,0,0, 3,1,1,1));

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    check("reset_u4", mv(0,0,0,0,0,0, 0,0,0,0));
    check("reset_u5", mv(1,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_u4", mv(0,0,0,0,0,0, 0,0,0,0));
    check("async_rst_u5", mv(1,0,0,0,0,0, 0,0,0,0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Table writes are discarded by reset
    run_vec(1000, mv(1,0,0,0,1,2, 2,2,0,0));
    run_vec(1001, mv(1,0,0,0,1,4, 4,4,0,0));

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/moore_seq_gen.md
MOORE_SEQ_GEN -- requirements
Module: moore_seq_gen

Interface
REQ-001 SHALL have parameter NUM_STATES, default 4, number of sequence states (legal 2..16).
REQ-002 SHALL have parameter OUT_W, default 1, width of per-state output word (legal 1..16).
REQ-003 SHALL have localparam STATE_W = $clog2(NUM_STATES), state index width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  advance sequence by one step this cycle.
REQ-007 SHALL have port mode  input  2  0 free-run wrap, 1 one-shot, 2 ping-pong, 3 reserved (treated as 0).
REQ-008 SHALL have port dir  input  1  0 up, 1 down; used in modes 0/1 only.
REQ-009 SHALL have port load  input  1  force state to load_state.
REQ-010 SHALL have port load_state  input  STATE_W  target state for load.
REQ-011 SHALL have ports wr_en input 1, wr_addr input STATE_W, wr_data input OUT_W: output-table write port (see REQ-030).
REQ-012 SHALL have port state_out  output  STATE_W  current state index, registered.
REQ-013 SHALL have port out  output  OUT_W  Moore output = table[state_out], registered.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse on sequence boundary event.
REQ-015 SHALL have port done  output  1  level, one-shot terminal state reached.

Function
REQ-016 SHALL keep out equal to table[state_out] in every cycle after reset; no combinational path from inputs to out.
REQ-017 SHALL give load priority over en: load=1 sets state_out=load_state next edge, clears done, clears wrap, sets ping-pong direction to up.
REQ-018 SHALL treat load_state >= NUM_STATES as 0.
REQ-019 SHALL hold state_out, out, done when en=0 and load=0; wrap=0 that cycle.
REQ-020 Mode 0 SHALL step +1 (dir=0) or -1 (dir=1) modulo NUM_STATES; wrap=1 on the cycle after NUM_STATES-1 -> 0 (up) or 0 -> NUM_STATES-1 (down).
REQ-021 Mode 1 SHALL step per dir and stop at terminal state (NUM_STATES-1 up, 0 down); done=1 from the edge entering terminal and held; en ignored while done=1; wrap=1 for one cycle on entry to terminal.
REQ-022 Mode 1 started with state already at terminal and en=1 SHALL set done=1 and wrap=1 without moving state.
REQ-023 Mode 2 SHALL step with internal direction, reversing at NUM_STATES-1 and 0 (sequence 0,1,..,N-1,N-2,..,0,1..); wrap=1 on cycle after entering either end state; no state repeated at turn.
REQ-024 SHALL clear done when mode changes away from 1 or on load.
REQ-025 A mode change SHALL take effect on the next en step; state_out is not altered by the change itself.
REQ-026 SHALL have one-step latency: en sampled at edge k gives new state_out and matching out after edge k.
REQ-027 SHALL clamp state_out to valid range; state never exceeds NUM_STATES-1 for any NUM_STATES (non-power-of-two included).

Reset
REQ-028 SHALL on rst=1 asynchronously set state_out=0, out=table reset entry 0, wrap=0, done=0, ping-pong direction=up.
REQ-029 SHALL on rst set table entry i to i[OUT_W-1:0] zero-extended (OUT_W=1: alternating 0,1,0,1); rst mid-sequence discards progress and table writes.

Configuration
REQ-030 With macro MOORE_SEQ_TABLE_WR_EN defined, wr_en=1 SHALL write wr_data to table[wr_addr] at the edge (wr_addr >= NUM_STATES ignored); if the written entry is the state being entered or held that edge, out SHALL show wr_data after that edge (write bypass).
REQ-031 Without MOORE_SEQ_TABLE_WR_EN, wr_en/wr_addr/wr_data SHALL be ignored and the table SHALL be constants equal to REQ-029 values (no table registers).

Verification
REQ-032 Defaults, mode 0, dir 0, en=1 for 8 cycles -> state_out 1,2,3,0,1,2,3,0; out 1,0,1,0,1,0,1,0; wrap=1 on cycles 4 and 8.
REQ-033 NUM_STATES=5, mode 1, dir 1, load_state=3 then en=1 -> state 3,2,1,0,0; done=1 at 0 and held; wrap one pulse; load resumes.
REQ-034 NUM_STATES=4, mode 2, en=1 for 8 cycles from 0 -> 1,2,3,2,1,0,1,2; wrap after entering 3 and 0.
REQ-035 load=1 and en=1 same cycle, load_state=2 -> state_out=2; load_state=7 with NUM_STATES=5 -> 0.
REQ-036 TABLE_WR_EN, OUT_W=8: write 0xA5 to entry 2 while stepping 1->2 -> out=0xA5 that edge; without macro out=0x02.
REQ-037 rst asserted mid-sequence at state 3, done=1 -> immediately state_out=0, out=0, done=0, wrap=0, no clk needed.
